amax10_qsys_nios2_gen2_cpu_oci_trace_monitor: RTL and testbench



---
 rtl/amax10_qsys_nios2_gen2_cpu_oci_trace_pkg.sv | 7 +
 rtl/amax10_qsys_nios2_gen2_cpu_oci_trace_monitor_if.sv | 30 +++
 rtl/amax10_qsys_nios2_gen2_cpu_oci_trace_fifo.sv | 39 +++
 rtl/amax10_qsys_nios2_gen2_cpu_oci_trace_monitor.sv | 47 ++++
 tb/tb_amax10_qsys_nios2_gen2_cpu_oci_trace_monitor.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/amax10_qsys_nios2_gen2_cpu_oci_trace_pkg.sv
// amax10_qsys_nios2_gen2_cpu_oci_trace_pkg: shared state encoding and level width helper
package amax10_qsys_nios2_gen2_cpu_oci_trace_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, DRAIN = 2'd2, ENDED = 2'd3} state_t;
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/amax10_qsys_nios2_gen2_cpu_oci_trace_monitor_if.sv
// amax10_qsys_nios2_gen2_cpu_oci_trace_monitor_if: capture, control and reader signals of the trace monitor
interface amax10_qsys_nios2_gen2_cpu_oci_trace_monitor_if #(
  parameter int DATA_W = 30,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
);
  logic                  capture_en;
  logic                  dct_valid;
  logic [DATA_W-1:0]     dct_buffer;
  logic [CNT_W-1:0]      dct_count;
  logic                  test_ending;
  logic                  test_has_ended;
  logic                  rd_ready;
  logic                  rd_valid;
  logic [CNT_W+DATA_W-1:0] rd_data;
  logic [amax10_qsys_nios2_gen2_cpu_oci_trace_pkg::lvl_w(DEPTH)-1:0] level;
  logic                  overflow;
  logic [DROP_W-1:0]     drop_count;
  logic [1:0]            state;
  logic                  drain_done;
  modport master (
    output capture_en, dct_valid, dct_buffer, dct_count, test_ending, test_has_ended, rd_ready,
    input  rd_valid, rd_data, level, overflow, drop_count, state, drain_done
  );
  modport slave (
    input  capture_en, dct_valid, dct_buffer, dct_count, test_ending, test_has_ended, rd_ready,
    output rd_valid, rd_data, level, overflow, drop_count, state, drain_done
  );
endinterface

// File: rtl/amax10_qsys_nios2_gen2_cpu_oci_trace_fifo.sv
// amax10_qsys_nios2_gen2_cpu_oci_trace_fifo: first-word-fall-through buffer with occupancy count
module amax10_qsys_nios2_gen2_cpu_oci_trace_fifo
  import amax10_qsys_nios2_gen2_cpu_oci_trace_pkg::*;
#(
  parameter int W     = 34,
  parameter int DEPTH = 16,
  localparam int LW   = lvl_w(DEPTH),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  // storage is not reset; only pointers and level define what is valid
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= wr_data;
  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_en);
      rd_ptr <= rd_ptr + AW'(rd_en);
      level  <= level + LW'(wr_en) - LW'(rd_en);
    end
  assign rd_data = mem[rd_ptr];
  assign full    = level == LW'(DEPTH);
  assign empty   = level == '0;
endmodule

// File: rtl/amax10_qsys_nios2_gen2_cpu_oci_trace_monitor.sv
// amax10_qsys_nios2_gen2_cpu_oci_trace_monitor: captures debug frames, drains them to a reader, sequences end of test
module amax10_qsys_nios2_gen2_cpu_oci_trace_monitor
  import amax10_qsys_nios2_gen2_cpu_oci_trace_pkg::*;
#(
  parameter int DATA_W = 30,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16,
  localparam int LW    = lvl_w(DEPTH)
) (
  input logic clk,
  input logic reset,
  amax10_qsys_nios2_gen2_cpu_oci_trace_monitor_if.slave bus
);
  state_t                  st;
  logic                    full, empty, attempt, wr_en, rd_en;
  logic [CNT_W+DATA_W-1:0] head;
  logic [LW-1:0]           level;
  assign attempt = st == CAPTURE && bus.dct_valid && bus.dct_count != '0;
  assign wr_en   = attempt && !full;
  assign rd_en   = bus.rd_valid && bus.rd_ready;
  assign bus.rd_valid   = !empty && st != ENDED;
  assign bus.rd_data    = bus.rd_valid ? head : '0;
  assign bus.level      = level;
  assign bus.state      = st;
  assign bus.drain_done = st == ENDED && empty;
  amax10_qsys_nios2_gen2_cpu_oci_trace_fifo #(.W(CNT_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data({bus.dct_count, bus.dct_buffer}),
    .rd_en(rd_en), .rd_data(head), .full(full), .empty(empty), .level(level)
  );
  // end-of-test sequencer; hard stop overrides everything, ENDED holds until reset
  always_ff @(posedge clk or posedge reset)
    if (reset) st <= IDLE;
    else st <= bus.test_has_ended ? ENDED :
               st == CAPTURE ? (bus.test_ending ? DRAIN : bus.capture_en ? CAPTURE : IDLE) :
               st == IDLE    ? (bus.capture_en ? (bus.test_ending ? DRAIN : CAPTURE) : IDLE) :
               st == DRAIN   ? ((empty || (level == LW'(1) && rd_en)) ? ENDED : DRAIN) : ENDED;
  // a qualified frame arriving at a full buffer is lost; record it with a saturating count
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.overflow   <= 1'b0;
      bus.drop_count <= '0;
    end else if (attempt && full) begin
      bus.overflow <= 1'b1;
      if (~&bus.drop_count) bus.drop_count <= bus.drop_count + 1'b1;
    end
endmodule

// File: tb/tb_amax10_qsys_nios2_gen2_cpu_oci_trace_monitor.sv
// tb_amax10_qsys_nios2_gen2_cpu_oci_trace_monitor: directed and randomized checks against a queue-based model
module tb_amax10_qsys_nios2_gen2_cpu_oci_trace_monitor;
  localparam int DW = 30, CW = 4, DEP = 16, DRW = 5, LW = $clog2(DEP) + 1;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  amax10_qsys_nios2_gen2_cpu_oci_trace_monitor_if #(.DATA_W(DW), .CNT_W(CW), .DEPTH(DEP), .DROP_W(DRW)) bus ();
  amax10_qsys_nios2_gen2_cpu_oci_trace_monitor #(.DATA_W(DW), .CNT_W(CW), .DEPTH(DEP), .DROP_W(DRW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  int tests = 0, fails = 0;
  logic [CW+DW-1:0] mq[$];
  int ms, mdrop;
  bit movf;
  task automatic drive(input bit ce, dv, input int b, input int c, input bit te, the, rr);
    bus.capture_en = ce; bus.dct_valid = dv; bus.dct_buffer = DW'(b); bus.dct_count = CW'(c);
    bus.test_ending = te; bus.test_has_ended = the; bus.rd_ready = rr;
  endtask
  task automatic step();
    int lvl, ns;
    bit rd, att;
    lvl = mq.size();
    rd  = lvl != 0 && ms != 3 && bus.rd_ready;
    att = ms == 1 && bus.dct_valid && bus.dct_count != 0;
    ns  = ms;
    if (bus.test_has_ended) ns = 3;
    else if (ms == 1) ns = bus.test_ending ? 2 : (bus.capture_en ? 1 : 0);
    else if (ms == 0 && bus.capture_en) ns = bus.test_ending ? 2 : 1;
    else if (ms == 2 && (lvl == 0 || (lvl == 1 && rd))) ns = 3;
    @(posedge clk);
    if (rd) void'(mq.pop_front());
    if (att) begin
      if (lvl == DEP) begin
        movf = 1;
        if (mdrop < (1 << DRW) - 1) mdrop++;
      end else mq.push_back({bus.dct_count, bus.dct_buffer});
    end
    ms = ns;
    #1;
  endtask
  task automatic reset_dut();
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    mq.delete(); ms = 0; movf = 0; mdrop = 0;
  endtask
  task automatic test_reset();
    reset_dut();
    tests++;
    if ({bus.rd_valid, bus.rd_data, bus.level, bus.overflow, bus.drop_count, bus.state, bus.drain_done} !== '0) begin
      fails++; $display("FAIL reset_outputs got rv=%b data=%h lvl=%0d ovf=%b drop=%0d st=%0d dd=%b exp all 0",
        bus.rd_valid, bus.rd_data, bus.level, bus.overflow, bus.drop_count, bus.state, bus.drain_done);
    end
  endtask
  task automatic test_basic();
    logic [CW+DW-1:0] exp;
    reset_dut();
    drive(1, 0, 0, 0, 0, 0, 0); step();
    for (int i = 1; i <= 3; i++) begin drive(1, 1, i, i, 0, 0, 0); step(); end
    drive(1, 0, 0, 0, 0, 0, 0);
    tests++;
    if (bus.level !== LW'(3)) begin fails++; $display("FAIL basic_level got %0d exp 3", bus.level); end
    bus.rd_ready = 1;
    for (int i = 1; i <= 3; i++) begin
      exp = {CW'(i), DW'(i)};
      tests++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp) begin
        fails++; $display("FAIL basic_read%0d got v=%b %h exp %h", i, bus.rd_valid, bus.rd_data, exp);
      end
      step();
    end
    tests++;
    if (bus.rd_valid !== 1'b0 || bus.level !== '0) begin
      fails++; $display("FAIL basic_empty got v=%b lvl=%0d exp 0/0", bus.rd_valid, bus.level);
    end
  endtask
  task automatic test_overflow();
    logic [CW+DW-1:0] exp;
    reset_dut();
    drive(1, 0, 0, 0, 0, 0, 0); step();
    for (int i = 0; i < 20; i++) begin drive(1, 1, i * 7 + 1, i % 15 + 1, 0, 0, 0); step(); end
    drive(1, 0, 0, 0, 0, 0, 0);
    tests++;
    if (bus.level !== LW'(16) || bus.overflow !== 1'b1 || bus.drop_count !== DRW'(4)) begin
      fails++; $display("FAIL ovf_status got lvl=%0d ovf=%b drop=%0d exp 16/1/4", bus.level, bus.overflow, bus.drop_count);
    end
    bus.rd_ready = 1;
    for (int i = 0; i < 16; i++) begin
      exp = {CW'(i % 15 + 1), DW'(i * 7 + 1)};
      tests++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp) begin
        fails++; $display("FAIL ovf_read%0d got v=%b %h exp %h", i, bus.rd_valid, bus.rd_data, exp);
      end
      step();
    end
    tests++;
    if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL ovf_extra got rd_valid=%b exp 0", bus.rd_valid); end
  endtask
  task automatic test_empty_idle();
    reset_dut();
    for (int i = 0; i < 4; i++) begin drive(0, 1, i + 9, 5, 0, 0, 0); step(); end
    drive(1, 0, 0, 0, 0, 0, 0); step();
    for (int i = 0; i < 4; i++) begin drive(1, 1, i + 3, 0, 0, 0, 0); step(); end
    tests++;
    if (bus.level !== '0 || bus.drop_count !== '0 || bus.overflow !== 1'b0 || bus.state !== 2'd1) begin
      fails++; $display("FAIL empty_idle got lvl=%0d drop=%0d ovf=%b st=%0d exp 0/0/0/1",
        bus.level, bus.drop_count, bus.overflow, bus.state);
    end
  endtask
  task automatic test_drain();
    reset_dut();
    drive(1, 0, 0, 0, 0, 0, 0); step();
    for (int i = 0; i < 5; i++) begin drive(1, 1, i + 100, 2, 0, 0, 0); step(); end
    drive(1, 1, 200, 3, 1, 0, 0); step();
    for (int i = 0; i < 3; i++) begin drive(1, 1, i + 300, 4, 0, 0, 0); step(); end
    tests++;
    if (bus.state !== 2'd2 || bus.level !== LW'(6)) begin
      fails++; $display("FAIL drain_enter got st=%0d lvl=%0d exp 2/6", bus.state, bus.level);
    end
    drive(1, 0, 0, 0, 0, 0, 1);
    repeat (5) step();
    tests++;
    if (bus.state !== 2'd2 || bus.level !== LW'(1) || bus.drain_done !== 1'b0) begin
      fails++; $display("FAIL drain_mid got st=%0d lvl=%0d dd=%b exp 2/1/0", bus.state, bus.level, bus.drain_done);
    end
    step();
    tests++;
    if (bus.state !== 2'd3 || bus.level !== '0 || bus.drain_done !== 1'b1) begin
      fails++; $display("FAIL drain_end got st=%0d lvl=%0d dd=%b exp 3/0/1", bus.state, bus.level, bus.drain_done);
    end
  endtask
  task automatic test_stop();
    reset_dut();
    drive(1, 0, 0, 0, 0, 0, 0); step();
    for (int i = 0; i < 4; i++) begin drive(1, 1, i + 40, 1, 0, 0, 0); step(); end
    drive(1, 0, 0, 0, 0, 1, 0); step();
    tests++;
    if (bus.state !== 2'd3 || bus.rd_valid !== 1'b0 || bus.level !== LW'(4) || bus.drain_done !== 1'b0) begin
      fails++; $display("FAIL stop got st=%0d rv=%b lvl=%0d dd=%b exp 3/0/4/0", bus.state, bus.rd_valid, bus.level, bus.drain_done);
    end
    drive(1, 1, 7, 7, 0, 0, 1); repeat (2) step();
    tests++;
    if (bus.state !== 2'd3 || bus.level !== LW'(4) || bus.rd_valid !== 1'b0) begin
      fails++; $display("FAIL stop_frozen got st=%0d lvl=%0d rv=%b exp 3/4/0", bus.state, bus.level, bus.rd_valid);
    end
  endtask
  task automatic test_reset_mid();
    reset_dut();
    drive(1, 0, 0, 0, 0, 0, 0); step();
    for (int i = 0; i < 18; i++) begin drive(1, 1, i, 1, 0, 0, 0); step(); end
    drive(1, 0, 0, 0, 1, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0, 0);
    tests++;
    if (bus.state !== 2'd2 || bus.overflow !== 1'b1) begin
      fails++; $display("FAIL rstmid_pre got st=%0d ovf=%b exp 2/1", bus.state, bus.overflow);
    end
    #2 reset = 1;
    #1;
    tests++;
    if ({bus.rd_valid, bus.rd_data, bus.level, bus.overflow, bus.drop_count, bus.state, bus.drain_done} !== '0) begin
      fails++; $display("FAIL rstmid_async got rv=%b lvl=%0d ovf=%b drop=%0d st=%0d exp all 0",
        bus.rd_valid, bus.level, bus.overflow, bus.drop_count, bus.state);
    end
    reset_dut();
  endtask
  task automatic test_random();
    logic [CW+DW-1:0] exp;
    bit ev;
    reset_dut();
    for (int n = 0; n < 1500; n++) begin
      ev  = mq.size() != 0 && ms != 3;
      exp = ev ? mq[0] : '0;
      tests++;
      if (bus.rd_valid !== ev || bus.rd_data !== exp) begin
        fails++; $display("FAIL rnd_head cyc%0d got v=%b %h exp v=%b %h", n, bus.rd_valid, bus.rd_data, ev, exp);
      end
      tests++;
      if (bus.level !== LW'(mq.size()) || bus.state !== 2'(ms) || bus.overflow !== movf || bus.drop_count !== DRW'(mdrop)
          || bus.drain_done !== (ms == 3 && mq.size() == 0)) begin
        fails++; $display("FAIL rnd_status cyc%0d got lvl=%0d st=%0d ovf=%b drop=%0d dd=%b exp %0d/%0d/%b/%0d",
          n, bus.level, bus.state, bus.overflow, bus.drop_count, bus.drain_done, mq.size(), ms, movf, mdrop);
      end
      if (ms == 3 && $urandom_range(0, 9) == 0) reset_dut();
      else begin
        drive($urandom_range(0, 19) != 0, $urandom_range(0, 9) < 7, int'($urandom), int'($urandom_range(0, 15)),
              $urandom_range(0, 99) < 2, $urandom_range(0, 199) == 0, $urandom_range(0, 9) < (n % 300 < 150 ? 2 : 8));
        step();
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_empty_idle();
    test_drain();
    test_stop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
